// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver, 2-of-3 majority per bit, valid/ready output.
// Optional parity bit: define UART_RX_PARITY_EN (checked against PARITY_ODD).
module uart_rx_ovs #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
        OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_ovs: illegal parameter combination");
    end

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_VOTE = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_END  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  ferr_q, ferr_d;
    logic                  rx_s1, rx_s2;
    logic                  rx_sync;
    logic                  vote;
    logic                  at_vote;
    logic                  at_end;
    logic                  done;
    logic                  done_ferr;
`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic perr_q, perr_d;
    logic perr_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    assign rx_sync = rx_s2;
    assign vote    = (samp_q[0] & samp_q[1]) |
                     (samp_q[0] & rx_sync) |
                     (samp_q[1] & rx_sync);
    assign at_vote = tick && (cnt_q == T_VOTE);
    assign at_end  = tick && (cnt_q == T_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        done      = 1'b0;
        done_ferr = ferr_q | ~vote;
        if (tick) begin
            // Tick counter wraps only at a bit boundary.
            if (state_q != IDLE && state_q != BREAK) begin
                cnt_d = (cnt_q == T_END) ? '0 : cnt_q + 1'b1;
                if (cnt_q == T_S0) samp_d[0] = rx_sync;
                if (cnt_q == T_S1) samp_d[1] = rx_sync;
            end
            unique case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_d = START;
                        cnt_d   = '0;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
                START: begin
                    if (at_vote && vote) state_d = IDLE;
                    else if (at_end)     state_d = DATA;
                end
                DATA: begin
                    if (at_vote) shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
                    if (at_end) begin
                        if (bit_q == LAST_DATA) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_vote) perr_d = vote ^ (^shreg_q) ^ ODD;
                    if (at_end)  state_d = STOP;
                end
`endif
                STOP: begin
                    if (at_vote) begin
                        ferr_d = done_ferr;
                        // Last stop bit completes the frame at its centre.
                        if (bit_q == LAST_STOP) begin
                            done    = 1'b1;
                            state_d = (done_ferr && !rx_sync) ? BREAK : IDLE;
                        end
                    end else if (at_end) begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_sync) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_out  <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data_out  <= shreg_q;
                    frame_err <= done_ferr;
                    valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    perr_out  <= perr_q;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_out;
`else
    assign parity_err = 1'b0;
`endif

endmodule
